carfield_clk_div_ctrl: RTL
==========================

# carfield_clk_div_ctrl

Per-domain clock-enable divider for the Carfield clock tree, sitting directly downstream of the PLL. It runs on the PLL output clock and produces one clock-enable stream per Carfield clock domain: host, peripheral, alt and secure, indexed 0..3 in that order. Each enable stream drives the domain's clock-gating cell. Divide ratios are reprogrammed at runtime through a valid/ready config port, and changes take effect only at a period boundary, so no domain ever sees a truncated period.

## Interface
Parameters
- NumDomains, 4: number of clock domains. Index 0 = host, 1 = periph, 2 = alt, 3 = secure.
- DivWidth, 8: width of a divide value.
- DefaultDiv, 1: divide value loaded into every domain at reset; 0 means the domain is stopped.

Ports
- clk_i  in  1  PLL output clock; the only clock.
- rst_ni  in  1  asynchronous, active-low reset.
- cfg_valid_i  in  1  config request valid.
- cfg_ready_o  out  1  config request ready.
- cfg_idx_i  in  max(1,$clog2(NumDomains))  target domain index.
- cfg_div_i  in  DivWidth  new divide value; 0 = stop the domain.
- tick_o  out  NumDomains  per-domain clock enable, decoded from flops only.
- pending_o  out  NumDomains  per-domain flag: an update is waiting for its boundary.
- running_o  out  NumDomains  per-domain flag: the domain is in RUN or PEND.

## Operation
- Each domain has its own FSM with states STOP, RUN and PEND, plus these registers: cnt_q, div_q and pend_q (all DivWidth bits).
- A config request is accepted when cfg_valid_i && cfg_ready_o.
  - cfg_ready_o = !pending_o[cfg_idx_i].
  - If cfg_idx_i >= NumDomains, cfg_ready_o = 1. The request is accepted and discarded.
- tick_o[d] = (state is RUN or PEND) && cnt_q == div_q-1.
- STOP
  - cnt_q = 0, tick_o = 0.
  - Accepted write with N != 0: div_q <= N, cnt_q <= 0, go to RUN.
  - Accepted write with N == 0: no-op, stay in STOP.
- RUN
  - cnt_q increments by 1 and wraps to 0 when cnt_q == div_q-1 (the tick cycle).
  - Accepted write on a non-tick cycle: pend_q <= N, go to PEND.
  - Accepted write on a tick cycle: applied at this boundary.
    - N != 0: div_q <= N, cnt_q <= 0, stay in RUN.
    - N == 0: go to STOP.
- PEND
  - Counting continues with the old div_q.
  - On the tick cycle:
    - pend_q != 0: div_q <= pend_q, cnt_q <= 0, go to RUN.
    - pend_q == 0: go to STOP.
  - Further writes to this domain are back-pressured (ready low).
- Outputs: pending_o[d] = (state == PEND); running_o[d] = (state != STOP).
- Domains are fully independent. A write to one domain never perturbs another's count.
- Divide values are unsigned. div_q-1 is computed at DivWidth bits. div_q == 0 never occurs in RUN or PEND.

## Timing
- Reset (asynchronous assert, synchronous release):
  - DefaultDiv != 0: every domain enters RUN with cnt_q = 0, div_q = DefaultDiv.
  - DefaultDiv == 0: every domain enters STOP.
  - pend_q = 0, pending_o = 0.
  - tick_o = 1 immediately in reset only if DefaultDiv == 1; otherwise 0.
  - running_o = (DefaultDiv != 0).
  - cfg_ready_o = 1.
- Write of N accepted in STOP at cycle T: first tick at T+N, then one tick every N cycles. N = 1 gives tick_o high every cycle from T+1.
- Write accepted in RUN at a non-tick cycle T:
  - pending_o rises at T+1.
  - The old period completes on the tick at cycle B (B > T).
  - pending_o falls at B+1.
  - Next tick is at B+N.
- Write accepted on a tick cycle T: no PEND state is entered, and the next tick is at T+N.
- Reset asserted mid-period or mid-PEND: pending data is discarded and the reset values apply at once.
- Tick gap is exactly div_q cycles (no jitter). The maximum period is 2^DivWidth-1 cycles.

## Test plan
- Reset release with DefaultDiv=1: tick_o = 4'b1111 on every cycle, running_o = 4'hF, cfg_ready_o = 1.
- Write idx=1, div=4 at T (domain in RUN, div 1; T is a tick cycle): tick_o[1] at T+4, T+8, T+12; other bits stay continuously high.
- Mid-period update: domain 2 at div=5 with cnt_q=1, write div=3 → pending_o[2]=1. The remaining old period ticks at cnt_q=4 (cycle B); pending_o[2] clears at B+1; next ticks at B+3, B+6.
- Back-pressure: second write to domain 2 while pending_o[2]=1 → cfg_ready_o=0 until the boundary; then it is accepted and applied at the following boundary. A write to domain 0 in the same window is accepted immediately.
- Stop/restart: write div=0 to domain 3 in RUN → tick_o[3] stops after its current period and running_o[3]=0. Write div=2 at T → ticks at T+2, T+4.
- Assert rst_ni low while domain 1 is in PEND → pending_o=0 asynchronously. After release, domain 1 is back at DefaultDiv and the pending value is never applied.

Source files
------------

// File: rtl/carfield_clk_div_ctrl.sv
// Per-domain clock-enable divider: one counter/FSM per Carfield domain, ticks every div_q cycles.
// Ratio updates land only on a period boundary; a domain with an update queued back-pressures its config writes.
module carfield_clk_div_ctrl #(
   parameter  int unsigned NumDomains = 4,
   parameter  int unsigned DivWidth   = 8,
   parameter  int unsigned DefaultDiv = 1,
   localparam int unsigned IdxW       = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cfg_valid_i,
   output logic                  cfg_ready_o,
   input  logic [IdxW-1:0]       cfg_idx_i,
   input  logic [DivWidth-1:0]   cfg_div_i,
   output logic [NumDomains-1:0] tick_o,
   output logic [NumDomains-1:0] pending_o,
   output logic [NumDomains-1:0] running_o
);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   localparam logic [DivWidth-1:0] DefDiv   = DivWidth'(DefaultDiv);
   localparam state_e              RstState = (DefaultDiv != 0) ? ST_RUN : ST_STOP;

   logic [NumDomains-1:0] w_pending;
   logic                  w_ready;

   // Out-of-range indices stay ready so the request is swallowed instead of stalling the port.
   always_comb begin
      w_ready = 1'b1;
      for (int i = 0; i < NumDomains; i++) begin
         if (cfg_idx_i == IdxW'(i)) begin
            w_ready = !w_pending[i];
         end
      end
   end

   assign cfg_ready_o = w_ready;
   assign pending_o   = w_pending;

   for (genvar d = 0; d < NumDomains; d++) begin : g_dom
      state_e              r_state, w_state_nxt;
      logic [DivWidth-1:0] r_cnt, r_div, r_pend;
      logic [DivWidth-1:0] w_cnt_nxt, w_div_nxt, w_pend_nxt;
      logic [DivWidth-1:0] w_div_m1;
      logic                w_active, w_tick, w_wr;

      assign w_active = (r_state == ST_RUN) || (r_state == ST_PEND);
      assign w_div_m1 = r_div - DivWidth'(1);
      assign w_tick   = w_active && (r_cnt == w_div_m1);
      assign w_wr     = cfg_valid_i && w_ready && (cfg_idx_i == IdxW'(d));

      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = w_tick ? '0 : r_cnt + DivWidth'(1);
         w_div_nxt   = r_div;
         w_pend_nxt  = r_pend;
         unique case (r_state)
            ST_STOP: begin
               w_cnt_nxt = '0;
               if (w_wr && (cfg_div_i != '0)) begin
                  w_div_nxt   = cfg_div_i;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_wr) begin
                  if (!w_tick) begin
                     w_pend_nxt  = cfg_div_i;
                     w_state_nxt = ST_PEND;
                  end else if (cfg_div_i != '0) begin
                     w_div_nxt = cfg_div_i;
                  end else begin
                     w_state_nxt = ST_STOP;
                  end
               end
            end
            ST_PEND: begin
               // Old ratio finishes its period before the queued one takes over.
               if (w_tick) begin
                  if (r_pend != '0) begin
                     w_div_nxt   = r_pend;
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_state_nxt = ST_STOP;
                  end
               end
            end
            default: begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_STOP;
            end
         endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_state <= RstState;
            r_cnt   <= '0;
            r_div   <= DefDiv;
            r_pend  <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_pend  <= w_pend_nxt;
         end
      end

      assign tick_o[d]    = w_tick;
      assign w_pending[d] = (r_state == ST_PEND);
      assign running_o[d] = (r_state != ST_STOP);
   end

endmodule
